// File: rtl/mac_unit_vert_seq.sv
// mac_unit_vert_seq: sequential vertical bit-column MAC.
// Latches one signed activation vector and its per-group sums. It then takes
// WEIGHT_BITS weight bit-columns, LSB column first, one per handshake, and
// returns one signed dot product per vector.
// Optional feature macro: MAC_VERT_HAMMING_EN adds a per-column single
// activation correction term (ham_sel / ham_sign) and one extra result bit.
module mac_unit_vert_seq #(
   parameter int DATA_WIDTH    = 8,
   parameter int VEC_LENGTH    = 16,
   parameter int GROUP_SIZE    = 8,
   parameter int NUM_GROUPS    = VEC_LENGTH / GROUP_SIZE,
   parameter int LANES         = GROUP_SIZE / 2,
   parameter int WEIGHT_BITS   = 8,
   parameter int SEL_WIDTH     = $clog2(GROUP_SIZE) + 1,
`ifdef MAC_VERT_HAMMING_EN
   parameter int HAM_SEL_WIDTH = $clog2(VEC_LENGTH) + 1,
   parameter int RESULT_WIDTH  = DATA_WIDTH + $clog2(VEC_LENGTH) + WEIGHT_BITS + 2
`else
   parameter int RESULT_WIDTH  = DATA_WIDTH + $clog2(VEC_LENGTH) + WEIGHT_BITS + 1
`endif
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [VEC_LENGTH*DATA_WIDTH-1:0]    act,
   input  logic                                act_valid,
   output logic                                act_ready,
   input  logic [NUM_GROUPS*LANES*SEL_WIDTH-1:0] act_sel,
   input  logic [NUM_GROUPS-1:0]               is_skip_zero,
`ifdef MAC_VERT_HAMMING_EN
   input  logic [HAM_SEL_WIDTH-1:0]            ham_sel,
   input  logic                                ham_sign,
`endif
   input  logic                                col_valid,
   output logic                                col_ready,
   output logic [RESULT_WIDTH-1:0]             result,
   output logic                                out_valid,
   input  logic                                out_ready
);

   localparam int GSUM_W = DATA_WIDTH + $clog2(GROUP_SIZE);
   localparam int CNT_W  = (WEIGHT_BITS > 1) ? $clog2(WEIGHT_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(WEIGHT_BITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                          state_r;
   state_t                          state_next_s;
   logic                            act_ready_r;
   logic                            col_ready_r;
   logic                            out_valid_r;
   logic signed [RESULT_WIDTH-1:0]  result_r;
   logic signed [RESULT_WIDTH-1:0]  acc_r;
   logic [CNT_W-1:0]                col_cnt_r;

   logic signed [DATA_WIDTH-1:0]    act_r       [VEC_LENGTH];
   logic signed [GSUM_W-1:0]        group_sum_r [NUM_GROUPS];
   logic signed [GSUM_W-1:0]        group_sum_s [NUM_GROUPS];

   logic signed [RESULT_WIDTH-1:0]  col_sum_s;
   logic signed [RESULT_WIDTH-1:0]  col_term_s;
   logic signed [RESULT_WIDTH-1:0]  col_total_s;
   logic signed [RESULT_WIDTH-1:0]  acc_next_s;

   logic                            act_fire_s;
   logic                            col_fire_s;
   logic                            last_col_s;

   assign act_fire_s = act_valid & act_ready_r;
   assign col_fire_s = col_valid & col_ready_r;
   assign last_col_s = (col_cnt_r == LAST_COL);

   assign act_ready  = act_ready_r;
   assign col_ready  = col_ready_r;
   assign out_valid  = out_valid_r;
   assign result     = result_r;

   // Per-group sums of the incoming vector, captured alongside the vector.
   always_comb begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
         logic signed [GSUM_W-1:0] gs_s;
         gs_s = {GSUM_W{1'b0}};
         for (int i = 0; i < GROUP_SIZE; i++) begin
            gs_s = gs_s + GSUM_W'($signed(act[(g*GROUP_SIZE + i)*DATA_WIDTH +: DATA_WIDTH]));
         end
         group_sum_s[g] = gs_s;
      end
   end

   // Column sum: selected lanes per group, or the complement against group_sum.
   always_comb begin
      col_sum_s = {RESULT_WIDTH{1'b0}};
      for (int g = 0; g < NUM_GROUPS; g++) begin
         logic signed [RESULT_WIDTH-1:0] sel_sum_s;
         logic [SEL_WIDTH-1:0]           sel_s;
         int                             idx_s;
         sel_sum_s = {RESULT_WIDTH{1'b0}};
         for (int k = 0; k < LANES; k++) begin
            sel_s = act_sel[(g*LANES + k)*SEL_WIDTH +: SEL_WIDTH];
            idx_s = g*GROUP_SIZE + int'(sel_s);
            if (int'(sel_s) < GROUP_SIZE) begin
               sel_sum_s = sel_sum_s + RESULT_WIDTH'(act_r[idx_s]);
            end else begin
               sel_sum_s = sel_sum_s;
            end
         end
         if (is_skip_zero[g]) begin
            col_sum_s = col_sum_s + sel_sum_s;
         end else begin
            col_sum_s = col_sum_s + (RESULT_WIDTH'(group_sum_r[g]) - sel_sum_s);
         end
      end
   end

   // The MSB weight column carries negative significance.
   always_comb begin
      if (last_col_s) begin
         col_term_s = -col_sum_s;
      end else begin
         col_term_s = col_sum_s;
      end
   end

`ifdef MAC_VERT_HAMMING_EN
   logic signed [RESULT_WIDTH-1:0] ham_term_s;

   // Single-activation correction term; never subject to MSB negation.
   always_comb begin
      int ham_idx_s;
      ham_idx_s  = int'(ham_sel);
      ham_term_s = {RESULT_WIDTH{1'b0}};
      if (ham_idx_s < VEC_LENGTH) begin
         if (ham_sign) begin
            ham_term_s = -RESULT_WIDTH'(act_r[ham_idx_s]);
         end else begin
            ham_term_s = RESULT_WIDTH'(act_r[ham_idx_s]);
         end
      end else begin
         ham_term_s = {RESULT_WIDTH{1'b0}};
      end
   end

   assign col_total_s = col_term_s + ham_term_s;
`else
   assign col_total_s = col_term_s;
`endif

   assign acc_next_s = acc_r + (col_total_s <<< col_cnt_r);

   // Next-state logic for the vector sequencer.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (act_fire_s) begin
               state_next_s = RUN;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            if (col_fire_s && last_col_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DONE;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State, handshake flags, accumulator, column counter and result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         act_ready_r <= 1'b1;
         col_ready_r <= 1'b0;
         out_valid_r <= 1'b0;
         result_r    <= {RESULT_WIDTH{1'b0}};
         acc_r       <= {RESULT_WIDTH{1'b0}};
         col_cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r     <= state_next_s;
         act_ready_r <= (state_next_s == IDLE);
         col_ready_r <= (state_next_s == RUN);
         out_valid_r <= (state_next_s == DONE);
         if (act_fire_s) begin
            acc_r     <= {RESULT_WIDTH{1'b0}};
            col_cnt_r <= {CNT_W{1'b0}};
         end else if (col_fire_s) begin
            acc_r     <= acc_next_s;
            col_cnt_r <= col_cnt_r + CNT_W'(1);
            if (last_col_s) begin
               result_r <= acc_next_s;
            end
         end
      end
   end

   // Activation vector and group sums, captured on the vector handshake.
   always_ff @(posedge clk) begin
      if (act_fire_s) begin
         for (int i = 0; i < VEC_LENGTH; i++) begin
            act_r[i] <= $signed(act[i*DATA_WIDTH +: DATA_WIDTH]);
         end
         for (int g = 0; g < NUM_GROUPS; g++) begin
            group_sum_r[g] <= group_sum_s[g];
         end
      end
   end

endmodule

// File: tb/tb_mac_unit_vert_seq.sv
// Testbench for mac_unit_vert_seq (default parameters, feature macro undefined).
// Expected results come from a weight-domain model and are queued when a
// vector is driven, then popped when the DUT presents its result.
module tb_mac_unit_vert_seq;

   localparam int DW = 8;
   localparam int VL = 16;
   localparam int GS = 8;
   localparam int NG = 2;
   localparam int LN = 4;
   localparam int WB = 8;
   localparam int SW = 4;
   localparam int RW = 21;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [VL*DW-1:0]     act;
   logic                 act_valid;
   logic                 act_ready;
   logic [NG*LN*SW-1:0]  act_sel;
   logic [NG-1:0]        is_skip_zero;
   logic                 col_valid;
   logic                 col_ready;
   logic [RW-1:0]        result;
   logic                 out_valid;
   logic                 out_ready;

   int n_checks = 0;
   int n_pass   = 0;

   logic [RW-1:0]        sb_q [$];
   logic signed [DW-1:0] tv_act  [VL];
   logic [SW-1:0]        tv_sel  [WB][NG*LN];
   logic [NG-1:0]        tv_skip [WB];

   always #5 clk = ~clk;

   mac_unit_vert_seq dut (
      .clk          (clk),
      .reset        (reset),
      .act          (act),
      .act_valid    (act_valid),
      .act_ready    (act_ready),
      .act_sel      (act_sel),
      .is_skip_zero (is_skip_zero),
      .col_valid    (col_valid),
      .col_ready    (col_ready),
      .result       (result),
      .out_valid    (out_valid),
      .out_ready    (out_ready)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_uniform(input logic signed [DW-1:0] a, input logic [NG-1:0] skip);
      for (int i = 0; i < VL; i++) tv_act[i] = a;
      for (int c = 0; c < WB; c++) begin
         for (int l = 0; l < NG*LN; l++) tv_sel[c][l] = 4'd8;
         tv_skip[c] = skip;
      end
   endtask

   task automatic set_random();
      for (int i = 0; i < VL; i++) tv_act[i] = 8'($urandom());
      for (int c = 0; c < WB; c++) begin
         for (int l = 0; l < NG*LN; l++) tv_sel[c][l] = 4'($urandom_range(0, 15));
         tv_skip[c] = 2'($urandom());
      end
   endtask

   // Weight-domain model: each activation gets the signed weight implied by
   // how many lanes select it per column, then a plain dot product.
   function automatic logic [RW-1:0] model_result();
      longint acc;
      longint w;
      longint sig;
      int     cnt;
      int     coef;
      int     g;
      int     j;
      acc = 0;
      for (int i = 0; i < VL; i++) begin
         g = i / GS;
         j = i % GS;
         w = 0;
         for (int c = 0; c < WB; c++) begin
            cnt = 0;
            for (int k = 0; k < LN; k++) begin
               if (tv_sel[c][g*LN + k] == SW'(j)) cnt++;
            end
            coef = tv_skip[c][g] ? cnt : (1 - cnt);
            sig  = (c == WB-1) ? -(longint'(1) << c) : (longint'(1) << c);
            w    = w + sig * longint'(coef);
         end
         acc = acc + w * longint'(tv_act[i]);
      end
      return RW'(acc);
   endfunction

   task automatic drive_act();
      for (int i = 0; i < VL; i++) act[i*DW +: DW] = tv_act[i];
   endtask

   task automatic drive_col(input int c);
      for (int l = 0; l < NG*LN; l++) act_sel[l*SW +: SW] = tv_sel[c][l];
      is_skip_zero = tv_skip[c];
   endtask

   // Drives one vector and its WB columns; returns right after the final
   // column handshake with the DUT expected to be in DONE.
   task automatic run_vector(input bit stall, output logic [RW-1:0] res,
                             output bit lat_ok, output bit early, output bit tmo);
      int n;
      int c;
      bit hs;
      tmo   = 1'b0;
      early = 1'b0;
      n     = 0;
      while (act_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (act_ready !== 1'b1) tmo = 1'b1;
      drive_act();
      act_valid = 1'b1;
      tick();
      act_valid = 1'b0;
      act = {$urandom(), $urandom(), $urandom(), $urandom()};
      c = 0;
      n = 0;
      while (c < WB && n < 200) begin
         if (stall && (n % 2 == 1)) begin
            col_valid    = 1'b0;
            act_sel      = $urandom();
            is_skip_zero = 2'($urandom());
         end else begin
            col_valid = 1'b1;
            drive_col(c);
         end
         hs = col_valid && (col_ready === 1'b1);
         if (out_valid === 1'b1) early = 1'b1;
         tick();
         n++;
         if (hs) c++;
      end
      col_valid = 1'b0;
      if (c < WB) tmo = 1'b1;
      res    = result;
      lat_ok = (out_valid === 1'b1);
   endtask

   task automatic release_vector();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      act          = '0;
      act_valid    = 1'b0;
      act_sel      = '0;
      is_skip_zero = '0;
      col_valid    = 1'b0;
      out_ready    = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (act_ready !== 1'b1) $display("FAIL reset_act_ready: got %b need 1", act_ready);
      else n_pass++;
      n_checks++;
      if (col_ready !== 1'b0) $display("FAIL reset_col_ready: got %b need 0", col_ready);
      else n_pass++;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b need 0", out_valid);
      else n_pass++;
      n_checks++;
      if (result !== 21'd0) $display("FAIL reset_result: got %0d need 0", result);
      else n_pass++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      logic [RW-1:0] exp;
      logic [RW-1:0] r;
      logic [RW-1:0] e;
      bit lat;
      bit early;
      bit tmo;
      for (int t = 0; t < 4; t++) begin
         case (t)
            0: begin set_uniform(8'sd3, 2'b11); exp = 21'd0; end
            1: begin set_uniform(8'sd1, 2'b00); exp = -21'sd16; end
            2: begin set_uniform(8'sd0, 2'b11); tv_act[0] = 8'sd100; tv_sel[0][0] = 4'd0; exp = 21'd100; end
            default: begin set_uniform(8'sd0, 2'b11); tv_act[0] = -8'sd128; tv_sel[7][0] = 4'd0; exp = 21'd16384; end
         endcase
         sb_q.push_back(exp);
         run_vector(1'b0, r, lat, early, tmo);
         e = sb_q.pop_front();
         n_checks++;
         if (tmo || r !== e) $display("FAIL directed%0d_result: got %0d need %0d (timeout=%0d)", t, $signed(r), $signed(e), tmo);
         else n_pass++;
         n_checks++;
         if (!lat || early) $display("FAIL directed%0d_latency: out_valid after last column %0d early %0d, need 1/0", t, lat, early);
         else n_pass++;
         release_vector();
      end
   endtask

   task automatic test_stall();
      logic [RW-1:0] r0;
      logic [RW-1:0] r1;
      logic [RW-1:0] e;
      bit lat;
      bit early;
      bit tmo;
      set_random();
      sb_q.push_back(model_result());
      sb_q.push_back(model_result());
      run_vector(1'b0, r0, lat, early, tmo);
      e = sb_q.pop_front();
      n_checks++;
      if (tmo || r0 !== e) $display("FAIL nostall_result: got %0d need %0d", $signed(r0), $signed(e));
      else n_pass++;
      release_vector();
      run_vector(1'b1, r1, lat, early, tmo);
      e = sb_q.pop_front();
      n_checks++;
      if (tmo || r1 !== e) $display("FAIL stall_result: got %0d need %0d", $signed(r1), $signed(e));
      else n_pass++;
      n_checks++;
      if (!lat || early) $display("FAIL stall_latency: out_valid after last column %0d early %0d, need 1/0", lat, early);
      else n_pass++;
      act_valid = 1'b1;
      col_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || result !== e || act_ready !== 1'b0 || col_ready !== 1'b0)
            $display("FAIL done_hold%0d: out_valid %b result %0d act_ready %b col_ready %b, need 1 %0d 0 0",
                     i, out_valid, $signed(result), act_ready, col_ready, $signed(e));
         else n_pass++;
      end
      act_valid = 1'b0;
      col_valid = 1'b0;
      release_vector();
      n_checks++;
      if (act_ready !== 1'b1 || out_valid !== 1'b0 || col_ready !== 1'b0)
         $display("FAIL done_release: act_ready %b out_valid %b col_ready %b, need 1 0 0", act_ready, out_valid, col_ready);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [RW-1:0] r;
      logic [RW-1:0] e;
      bit lat;
      bit early;
      bit tmo;
      set_uniform(8'sd1, 2'b00);
      drive_act();
      act_valid = 1'b1;
      tick();
      act_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         col_valid = 1'b1;
         drive_col(c);
         tick();
      end
      col_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if (act_ready !== 1'b1 || out_valid !== 1'b0 || result !== 21'd0 || col_ready !== 1'b0)
         $display("FAIL midreset_state: act_ready %b out_valid %b result %0d col_ready %b, need 1 0 0 0",
                  act_ready, out_valid, $signed(result), col_ready);
      else n_pass++;
      sb_q.push_back(-21'sd16);
      run_vector(1'b0, r, lat, early, tmo);
      e = sb_q.pop_front();
      n_checks++;
      if (tmo || r !== e) $display("FAIL midreset_fresh: got %0d need %0d", $signed(r), $signed(e));
      else n_pass++;
      release_vector();
   endtask

   task automatic test_back_to_back();
      logic [RW-1:0] r;
      logic [RW-1:0] e;
      bit lat;
      bit early;
      bit tmo;
      for (int v = 0; v < 6; v++) begin
         set_random();
         sb_q.push_back(model_result());
         run_vector(1'b0, r, lat, early, tmo);
         e = sb_q.pop_front();
         n_checks++;
         if (tmo || r !== e || !lat) $display("FAIL b2b%0d_result: got %0d valid %0d need %0d valid 1", v, $signed(r), lat, $signed(e));
         else n_pass++;
         release_vector();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
